// File: rtl/cond_pkg.sv
// Shared types for the condition/flag unit: ARM condition encodings,
// flag bit positions and the flag-merge helper used on write-back.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // flag_w[1] selects the N,Z pair, flag_w[0] the C,V pair
  function automatic flags_t merge_flags(input flags_t cur, input logic [3:0] alu,
                                         input logic [1:0] flag_w);
    flags_t res;
    res = cur;
    if (flag_w[1]) begin
      res.n = alu[FLAG_N];
      res.z = alu[FLAG_Z];
    end else begin
      res.n = cur.n;
      res.z = cur.z;
    end
    if (flag_w[0]) begin
      res.c = alu[FLAG_C];
      res.v = alu[FLAG_V];
    end else begin
      res.c = cur.c;
      res.v = cur.v;
    end
    return res;
  endfunction

endpackage

// File: rtl/cond_flags_unit_if.sv
// Issue-side and writeback-side signals of the condition/flag unit.
// master = decode/ALU plus downstream consumer, slave = the unit itself.
interface cond_flags_unit_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic [3:0]       alu_flags;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic             out_valid;
  logic             out_ready;
  logic             pcs_q;
  logic             reg_w_q;
  logic             mem_w_q;
  logic             cond_ex_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output in_valid, cond, flag_w, alu_flags, pcs, reg_w, mem_w, no_write, out_ready,
    input  in_ready, out_valid, pcs_q, reg_w_q, mem_w_q, cond_ex_q, flags_q, squash_cnt
  );

  modport slave (
    input  in_valid, cond, flag_w, alu_flags, pcs, reg_w, mem_w, no_write, out_ready,
    output in_ready, out_valid, pcs_q, reg_w_q, mem_w_q, cond_ex_q, flags_q, squash_cnt
  );
endinterface

// File: rtl/cond_check.sv
// Pure combinational ARM condition evaluator against a flag snapshot.
module cond_check
  import cond_pkg::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   cond_ex_o
);

  logic nv_eq_s;
  assign nv_eq_s = (flags_i.n == flags_i.v);

  // Decode the condition field into a pass/fail against the flags
  always_comb begin
    cond_ex_o = 1'b1;
    case (cond_i)
      COND_EQ: cond_ex_o = flags_i.z;
      COND_NE: cond_ex_o = ~flags_i.z;
      COND_CS: cond_ex_o = flags_i.c;
      COND_CC: cond_ex_o = ~flags_i.c;
      COND_MI: cond_ex_o = flags_i.n;
      COND_PL: cond_ex_o = ~flags_i.n;
      COND_VS: cond_ex_o = flags_i.v;
      COND_VC: cond_ex_o = ~flags_i.v;
      COND_HI: cond_ex_o = flags_i.c & ~flags_i.z;
      COND_LS: cond_ex_o = ~flags_i.c | flags_i.z;
      COND_GE: cond_ex_o = nv_eq_s;
      COND_LT: cond_ex_o = ~nv_eq_s;
      COND_GT: cond_ex_o = ~flags_i.z & nv_eq_s;
      COND_LE: cond_ex_o = flags_i.z | ~nv_eq_s;
      COND_AL: cond_ex_o = 1'b1;
      COND_NV: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// Architectural flag register plus a single valid/ready stage that squashes
// the write enables of instructions whose condition fails.
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  cond_flags_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             in_ready_s;
  logic             accept_s;
  logic             cond_ex_s;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             pcs_q, pcs_d;
  logic             reg_w_q, reg_w_d;
  logic             mem_w_q, mem_w_d;
  logic             cond_ex_q, cond_ex_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  // Conditions see the flags left by older instructions, never alu_flags
  cond_check u_cond_check (
    .cond_i   (cond_e'(bus.cond)),
    .flags_i  (flags_q),
    .cond_ex_o(cond_ex_s)
  );

  assign in_ready_s = ~out_valid_q | bus.out_ready;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Next-state for the stage, flag register and squash counter
  always_comb begin
    out_valid_d  = out_valid_q;
    pcs_d        = pcs_q;
    reg_w_d      = reg_w_q;
    mem_w_d      = mem_w_q;
    cond_ex_d    = cond_ex_q;
    flags_d      = flags_q;
    squash_cnt_d = squash_cnt_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      pcs_d       = bus.pcs & cond_ex_s;
      reg_w_d     = bus.reg_w & cond_ex_s & ~bus.no_write;
      mem_w_d     = bus.mem_w & cond_ex_s;
      cond_ex_d   = cond_ex_s;
      if (cond_ex_s) begin
        flags_d = merge_flags(flags_q, bus.alu_flags, bus.flag_w);
      end else begin
        squash_cnt_d = (squash_cnt_q == CNT_MAX) ? CNT_MAX : squash_cnt_q + CNT_ONE;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset overrides stalls and accepts alike
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      pcs_q        <= 1'b0;
      reg_w_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      cond_ex_q    <= 1'b0;
      flags_q      <= '0;
      squash_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      pcs_q        <= pcs_d;
      reg_w_q      <= reg_w_d;
      mem_w_q      <= mem_w_d;
      cond_ex_q    <= cond_ex_d;
      flags_q      <= flags_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.pcs_q      = pcs_q;
  assign bus.reg_w_q    = reg_w_q;
  assign bus.mem_w_q    = mem_w_q;
  assign bus.cond_ex_q  = cond_ex_q;
  assign bus.flags_q    = flags_q;
  assign bus.squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: directed scenarios plus random
// traffic compared against a behavioural model of the condition table.
module tb_cond_flags_unit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  cond_flags_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_flags_unit #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic       m_ov, m_pcs, m_reg, m_mem, m_ce;
  logic [3:0] m_flags;
  int         m_cnt;

  logic [CNT_W+8:0] obs_v, exp_v;
  assign obs_v = {bus.out_valid, bus.pcs_q, bus.reg_w_q, bus.mem_w_q, bus.cond_ex_q,
                  bus.flags_q, bus.squash_cnt};
  assign exp_v = {m_ov, m_pcs, m_reg, m_mem, m_ce, m_flags, m_cnt[CNT_W-1:0]};

  // Pairs of conditions share a base predicate; odd codes invert it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base, always_pass;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    always_pass = 1'b0;
    base = 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: always_pass = 1'b1;
    endcase
    if (always_pass) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  // Advance the model with the currently driven inputs, then step the clock.
  task automatic cycle();
    logic acc, ce;
    if (reset) begin
      m_ov = 0; m_pcs = 0; m_reg = 0; m_mem = 0; m_ce = 0; m_flags = 4'b0000; m_cnt = 0;
    end else begin
      acc = bus.in_valid && (!m_ov || bus.out_ready);
      if (acc) begin
        ce    = ref_cond(bus.cond, m_flags);
        m_ov  = 1;
        m_ce  = ce;
        m_pcs = bus.pcs && ce;
        m_reg = bus.reg_w && ce && !bus.no_write;
        m_mem = bus.mem_w && ce;
        if (ce) begin
          if (bus.flag_w[1]) m_flags[3:2] = bus.alu_flags[3:2];
          if (bus.flag_w[0]) m_flags[1:0] = bus.alu_flags[1:0];
        end else if (m_cnt < CNT_MAX) begin
          m_cnt = m_cnt + 1;
        end
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic p, input logic r, input logic m, input logic nw);
    bus.in_valid = 1'b1; bus.cond = c; bus.flag_w = fw; bus.alu_flags = af;
    bus.pcs = p; bus.reg_w = r; bus.mem_w = m; bus.no_write = nw; bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.cond = 4'b0; bus.flag_w = 2'b0; bus.alu_flags = 4'b0;
    bus.pcs = 0; bus.reg_w = 0; bus.mem_w = 0; bus.no_write = 0; bus.out_ready = 1;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (obs_v !== '0) begin
      $display("FAIL reset_outputs got=%h want=0", obs_v); failures++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); failures++;
    end
  endtask

  task automatic test_basic();
    issue(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.reg_w_q, bus.flags_q} !== 6'b110100) begin
      $display("FAIL basic_al got=%b want=110100", {bus.out_valid, bus.reg_w_q, bus.flags_q});
      failures++;
    end
    checks++;
    if (obs_v !== exp_v) begin
      $display("FAIL basic_model got=%h want=%h", obs_v, exp_v); failures++;
    end
  endtask

  task automatic test_eq_ne();
    issue(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.mem_w_q !== 1'b1) begin
      $display("FAIL eq_mem_w got=%b want=1", bus.mem_w_q); failures++;
    end
    issue(4'b0001, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.mem_w_q, bus.flags_q, bus.squash_cnt} !== {1'b0, 4'b0100, 8'd1}) begin
      $display("FAIL ne_squash got=%b/%b/%0d want=0/0100/1", bus.mem_w_q, bus.flags_q,
               bus.squash_cnt);
      failures++;
    end
  endtask

  task automatic test_signed_conds();
    logic [3:0] fl [3];
    logic [3:0] c1 [3];
    logic [3:0] c2 [3];
    logic       e1 [3];
    logic       e2 [3];
    fl = '{4'b1000, 4'b1001, 4'b0010};
    c1 = '{4'b1010, 4'b1010, 4'b1000};
    c2 = '{4'b1011, 4'b1100, 4'b1001};
    e1 = '{1'b0, 1'b1, 1'b1};
    e2 = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(4'b1110, 2'b11, fl[i], 1'b0, 1'b0, 1'b0, 1'b0);
      issue(c1[i], 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.cond_ex_q, bus.pcs_q} !== {e1[i], e1[i]}) begin
        $display("FAIL signed_a%0d got=%b want=%b", i, bus.cond_ex_q, e1[i]); failures++;
      end
      issue(c2[i], 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.cond_ex_q, bus.pcs_q} !== {e2[i], e2[i]}) begin
        $display("FAIL signed_b%0d got=%b want=%b", i, bus.cond_ex_q, e2[i]); failures++;
      end
      checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL signed_model%0d got=%h want=%h", i, obs_v, exp_v); failures++;
      end
    end
  endtask

  task automatic test_flag_w();
    pulse_reset();
    issue(4'b1110, 2'b01, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.flags_q !== 4'b0011) begin
      $display("FAIL flag_w_cv got=%b want=0011", bus.flags_q); failures++;
    end
    issue(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.reg_w_q, bus.flags_q} !== 5'b00110) begin
      $display("FAIL cmp_no_write got=%b want=00110", {bus.reg_w_q, bus.flags_q});
      failures++;
    end
  endtask

  task automatic test_stall();
    logic [CNT_W+8:0] snap;
    issue(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    snap = obs_v;
    bus.in_valid = 1'b1; bus.cond = 4'b1110; bus.pcs = 1'b1; bus.mem_w = 1'b1;
    bus.reg_w = 1'b0; bus.flag_w = 2'b11; bus.alu_flags = 4'b1010; bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        $display("FAIL stall_ready%0d got=%b want=0", i, bus.in_ready); failures++;
      end
      cycle();
      checks++;
      if (obs_v !== snap || obs_v !== exp_v) begin
        $display("FAIL stall_hold%0d got=%h want=%h", i, obs_v, snap); failures++;
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL release_ready got=%b want=1", bus.in_ready); failures++;
    end
    cycle();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.pcs_q, bus.mem_w_q, bus.flags_q} !== 7'b1111010) begin
      $display("FAIL drain_accept got=%b want=1111010",
               {bus.out_valid, bus.pcs_q, bus.mem_w_q, bus.flags_q});
      failures++;
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL drain_empty got=%b want=0", bus.out_valid); failures++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.cond      = 4'($urandom_range(0, 15));
      bus.flag_w    = 2'($urandom_range(0, 3));
      bus.alu_flags = 4'($urandom_range(0, 15));
      bus.pcs       = 1'($urandom_range(0, 1));
      bus.reg_w     = 1'($urandom_range(0, 1));
      bus.mem_w     = 1'($urandom_range(0, 1));
      bus.no_write  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (bus.in_ready !== (!m_ov || bus.out_ready)) begin
        $display("FAIL rand_ready%0d got=%b want=%b", i, bus.in_ready, (!m_ov || bus.out_ready));
        failures++;
      end
      cycle();
      checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL rand_state%0d got=%h want=%h", i, obs_v, exp_v); failures++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_saturate_and_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    pulse_reset();
    bus.in_valid = 1'b1; bus.cond = 4'b0000; bus.flag_w = 2'b11; bus.alu_flags = 4'b1111;
    bus.pcs = 1'b1; bus.reg_w = 1'b1; bus.mem_w = 1'b1; bus.no_write = 1'b0;
    for (int i = 0; i < 300; i++) cycle();
    checks++;
    if ({bus.squash_cnt, bus.flags_q} !== {8'd255, 4'b0000}) begin
      $display("FAIL saturate got=%0d/%b want=255/0000", bus.squash_cnt, bus.flags_q);
      failures++;
    end
    bus.out_ready = 1'b0;
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || obs_v !== exp_v) begin
      $display("FAIL stall_before_reset got=%h want=%h", obs_v, exp_v); failures++;
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (obs_v !== '0) begin
      $display("FAIL reset_mid_stall got=%h want=0", obs_v); failures++;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eq_ne();
    test_signed_conds();
    test_flag_w();
    test_stall();
    test_random();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Condition/flag unit that consumes the `{N,Z,C,V}` flags produced by the n-bit ALU. It holds the architectural flag register and evaluates the ARM 4-bit condition field of each issued instruction against it. It squashes the write enables of failing instructions and forwards the gated enables one stage downstream over a valid/ready handshake. It sits between decode/ALU and register-file/memory/PC writeback.

## Interface
- `CNT_W`, 8: width of the saturating squash counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream instruction present.
- `in_ready` out 1: unit can accept this cycle.
- `cond` in 4: ARM condition field.
- `flag_w` in 2: bit1 = update N,Z; bit0 = update C,V.
- `alu_flags` in 4: `{N,Z,C,V}` from ALU, same cycle as `in_valid`.
- `pcs`, `reg_w`, `mem_w` in 1 each: ungated enables from decode.
- `no_write` in 1: compare-type op; suppresses `reg_w` even when the condition passes.
- `out_valid` out 1: gated result held.
- `out_ready` in 1: downstream accepts.
- `pcs_q`, `reg_w_q`, `mem_w_q` out 1 each: gated enables.
- `cond_ex_q` out 1: condition result of the held instruction.
- `flags_q` out 4: current architectural flags `{N,Z,C,V}`.
- `squash_cnt` out `CNT_W`: count of accepted instructions whose condition failed.

## Operation
- Accept = `in_valid & in_ready`. `in_ready = ~out_valid | out_ready` (single register stage, no bubble on continuous flow).
- `cond_ex` is evaluated combinationally from `cond` and the current `flags_q`, never from `alu_flags`. An instruction sees the flags left by earlier instructions, not its own.
- Condition codes:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: treated as 1.
- On accept, the stage register loads:
  - `pcs_q = pcs & cond_ex`
  - `reg_w_q = reg_w & cond_ex & ~no_write`
  - `mem_w_q = mem_w & cond_ex`
  - `cond_ex_q = cond_ex`
  - `out_valid = 1`
- On accept with `cond_ex`: `flags_q[3:2]` ← `alu_flags[3:2]` if `flag_w[1]`; `flags_q[1:0]` ← `alu_flags[1:0]` if `flag_w[0]`. A failing instruction never updates flags.
- On accept with `~cond_ex`: `squash_cnt` increments and saturates at all-ones.
- `out_valid & out_ready` with no accept: `out_valid` ← 0. Accept and drain in the same cycle: the new instruction replaces the old one, and `out_valid` stays 1.
- Stalled output (`out_valid & ~out_ready`): all `_q` outputs and `flags_q` hold; `in_ready = 0`.

## Timing
- Latency 1 cycle from accept to `out_valid`. Throughput 1 instruction per cycle.
- A flag update is visible to the condition evaluation of the very next accepted instruction, with no hazard gap.
- Reset (takes priority over every other event, including mid-stall):
  - `out_valid = 0`, `flags_q = 0000`, `squash_cnt = 0`.
  - `pcs_q`, `reg_w_q`, `mem_w_q`, `cond_ex_q` = 0.
  - `in_ready = 1` in the cycle after reset deasserts.
- `in_valid` with `in_ready = 0`: nothing happens. Upstream must hold its inputs.
- `_q` outputs are registered only; no combinational path from inputs to them. `in_ready` depends combinationally on `out_ready`.

## Structure
- Package `cond_pkg`:
  - `cond_e` enum covering EQ..AL plus 4'b1111.
  - Flag index constants `FLAG_N = 3`, `FLAG_Z = 2`, `FLAG_C = 1`, `FLAG_V = 0`.
  - `flags_t` packed struct `{n,z,c,v}`.
- One combinational sub-module `cond_check` (`cond`, `flags` in; `cond_ex` out). The top module holds the stage register, the flag register and the counter.

## Test plan
- Reset, then `cond=1110`, `flag_w=11`, `alu_flags=0100`, `reg_w=1` → next cycle `out_valid=1`, `reg_w_q=1`, `flags_q=0100`.
- With `flags_q=0100`: issue EQ (`mem_w=1`) then NE (`mem_w=1`) back-to-back → `mem_w_q` = 1 then 0; `squash_cnt=1`; flags unchanged by the NE even with `flag_w=11`.
- `flags_q=1000` (N=1, V=0): GE fails and LT passes. `flags_q=1001`: GE passes and GT passes. `flags_q=0010`: HI passes and LS fails.
- `flag_w=01`, `alu_flags=1111`, starting from `flags_q=0000` → `flags_q=0011`. CMP with `no_write=1`, `reg_w=1`, AL → `reg_w_q=0`, flags updated.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0` and outputs stable. Release → one drain+accept cycle, with `out_valid` staying 1.
- Issue 300 failing instructions with `CNT_W=8` → `squash_cnt=255`. Assert `reset` while `out_valid=1` and stalled → all outputs 0 next cycle.
